// File: rtl/uart_pkg.sv
// Shared UART constants: oversampling ratios, sample points, the rate
// mode type and small helpers for counter sizing and increment calculation.
package uart_pkg;

  localparam int OVS_16    = 16;
  localparam int OVS_8     = 8;
  localparam int SAMPLE_16 = OVS_16 / 2;
  localparam int SAMPLE_8  = OVS_8 / 2;

  typedef longint unsigned u64_t;

  typedef enum logic {
    MODE_16X = 1'b0,
    MODE_8X  = 1'b1
  } ovs_mode_e;

  // Smallest r such that 2**r >= value.
  function automatic int log2_ceil(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  localparam int CNT_W = log2_ceil(OVS_16);

  // round(ovs * baud * 2**acc_w / f_clk), the phase increment for a baud rate.
  function automatic u64_t calc_baud_inc(input int unsigned ovs,
                                         input int unsigned baud,
                                         input int unsigned f_clk,
                                         input int unsigned acc_w);
    u64_t num;
    num = (u64_t'(ovs) * u64_t'(baud)) << acc_w;
    return (num + u64_t'(f_clk / 2)) / u64_t'(f_clk);
  endfunction

  // Last count value of an oversample period for the given mode.
  function automatic logic [CNT_W-1:0] ovs_last(input ovs_mode_e mode);
    return (mode == MODE_8X) ? CNT_W'(OVS_8 - 1) : CNT_W'(OVS_16 - 1);
  endfunction

  // Count value just before the mid-bit sample point for the given mode.
  function automatic logic [CNT_W-1:0] sample_pre(input ovs_mode_e mode);
    return (mode == MODE_8X) ? CNT_W'(SAMPLE_8 - 1) : CNT_W'(SAMPLE_16 - 1);
  endfunction

endpackage

// File: rtl/baud_phase_acc.sv
// Fractional phase accumulator. The top bit of the stored value is the carry
// out of the last addition and doubles as the registered oversample tick.
module baud_phase_acc #(
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [ACC_W-1:0] inc,
  output logic             carry_next,
  output logic             os_tick
);

  logic [ACC_W:0] acc;
  logic [ACC_W:0] sum;

  // Next accumulator value; the carry is offered early so counters can
  // advance on the same edge that produces the tick.
  always_comb begin
    sum        = {1'b0, acc[ACC_W-1:0]} + {1'b0, inc};
    carry_next = enable && sum[ACC_W];
  end

  // Accumulator register, cleared while idle so a restart begins at phase 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (!enable) begin
      acc <= '0;
    end else begin
      acc <= sum;
    end
  end

  assign os_tick = acc[ACC_W];

endmodule

// File: rtl/uart_baud_gen.sv
// UART baud generator: phase accumulator feeding tx bit and rx sample
// counters, with increment and 8x/16x mode updates deferred to bit boundaries.
module uart_baud_gen #(
  parameter int ACC_W   = 16,
  parameter int RST_INC = 629
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             inc_wr,
  input  logic [ACC_W-1:0] inc_data,
  input  logic             u2x,
  input  logic             rx_resync,
  output logic             os_tick,
  output logic             rx_sample,
  output logic             tx_tick,
  output logic             inc_pending
);

  import uart_pkg::*;

  logic [ACC_W-1:0] active_inc;
  logic [ACC_W-1:0] pend_inc;
  logic             pend_valid;
  ovs_mode_e        mode;
  ovs_mode_e        req_mode;
  logic [CNT_W-1:0] tx_cnt;
  logic [CNT_W-1:0] rx_cnt;
  logic [CNT_W-1:0] cnt_last;
  logic [CNT_W-1:0] rx_pre;
  logic             carry_next;
  logic             tx_wrap;
  logic             mode_change;
  logic             rx_hit;
  logic             tx_tick_q;
  logic             rx_sample_q;
  logic             inc_pending_q;

  baud_phase_acc #(
    .ACC_W(ACC_W)
  ) u_phase_acc (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .inc        (active_inc),
    .carry_next (carry_next),
    .os_tick    (os_tick)
  );

  // Decode bit boundary, mode switch and mid-bit sample from the coming carry.
  always_comb begin
    req_mode    = u2x ? MODE_8X : MODE_16X;
    cnt_last    = ovs_last(mode);
    rx_pre      = sample_pre(mode);
    tx_wrap     = carry_next && (tx_cnt == cnt_last);
    mode_change = tx_wrap && (req_mode != mode);
    rx_hit      = carry_next && (rx_cnt == rx_pre) && !rx_resync && !mode_change;
  end

  // Oversample counters and registered tick strobes; a resync or mode switch
  // restarts the rx phase without touching the tx bit timing.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      tx_cnt      <= '0;
      rx_cnt      <= '0;
      tx_tick_q   <= 1'b0;
      rx_sample_q <= 1'b0;
    end else begin
      if (carry_next) begin
        tx_cnt <= tx_wrap ? '0 : tx_cnt + 1'b1;
      end
      if (rx_resync || mode_change) begin
        rx_cnt <= '0;
      end else if (carry_next) begin
        rx_cnt <= (rx_cnt == cnt_last) ? '0 : rx_cnt + 1'b1;
      end
      tx_tick_q   <= tx_wrap;
      rx_sample_q <= rx_hit;
    end
  end

  // Increment and mode bookkeeping: immediate while idle, deferred to the
  // next bit boundary while running so a frame never sees a mid-bit change.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_inc    <= ACC_W'(RST_INC);
      pend_inc      <= '0;
      pend_valid    <= 1'b0;
      mode          <= MODE_16X;
      inc_pending_q <= 1'b0;
    end else if (!enable) begin
      if (inc_wr) begin
        active_inc <= inc_data;
      end else if (pend_valid) begin
        active_inc <= pend_inc;
      end
      mode          <= req_mode;
      pend_valid    <= 1'b0;
      inc_pending_q <= 1'b0;
    end else if (tx_wrap) begin
      if (pend_valid) begin
        active_inc <= pend_inc;
      end
      if (inc_wr) begin
        pend_inc <= inc_data;
      end
      mode          <= req_mode;
      pend_valid    <= inc_wr;
      inc_pending_q <= inc_wr;
    end else begin
      if (inc_wr) begin
        pend_inc   <= inc_data;
        pend_valid <= 1'b1;
      end
      inc_pending_q <= inc_wr || pend_valid || (req_mode != mode);
    end
  end

  assign tx_tick     = tx_tick_q;
  assign rx_sample   = rx_sample_q;
  assign inc_pending = inc_pending_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed testbench for uart_baud_gen with hand-derived tick positions.
module tb_uart_baud_gen;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        inc_wr;
  logic [15:0] inc_data;
  logic        u2x;
  logic        rx_resync;
  logic        os_tick;
  logic        rx_sample;
  logic        tx_tick;
  logic        inc_pending;

  int checks   = 0;
  int failures = 0;

  uart_baud_gen #(
    .ACC_W   (16),
    .RST_INC (629)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .inc_wr      (inc_wr),
    .inc_data    (inc_data),
    .u2x         (u2x),
    .rx_resync   (rx_resync),
    .os_tick     (os_tick),
    .rx_sample   (rx_sample),
    .tx_tick     (tx_tick),
    .inc_pending (inc_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle, so outputs reflect that edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] got;
    rst = 1'b1; enable = 1'b0; inc_wr = 1'b0; inc_data = '0;
    u2x = 1'b0; rx_resync = 1'b0;
    repeat (2) step();
    got = {os_tick, rx_sample, tx_tick, inc_pending};
    checks++;
    if (got !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_outs got=%b exp=%b", got, 4'b0000);
    end
    rst = 1'b0;
    repeat (3) step();
    got = {os_tick, rx_sample, tx_tick, inc_pending};
    checks++;
    if (got !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL idle_outs got=%b exp=%b", got, 4'b0000);
    end
  endtask

  task automatic test_16x();
    logic [2:0] got, exp;
    logic [3:0] outs;
    enable = 1'b0; u2x = 1'b0; inc_wr = 1'b1; inc_data = 16'd16384;
    step();
    inc_wr = 1'b0;
    checks++;
    if (inc_pending !== 1'b0) begin
      failures++;
      $display("[TB] FAIL idle_write_pending got=%b exp=0", inc_pending);
    end
    enable = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      step();
      got = {os_tick, rx_sample, tx_tick};
      exp = {(n % 4 == 0), (n % 64 == 32), (n % 64 == 0)};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL run16x edge=%0d os/rx/tx got=%b exp=%b", n, got, exp);
      end
    end
    enable = 1'b0;
    step();
    outs = {os_tick, rx_sample, tx_tick, inc_pending};
    checks++;
    if (outs !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL disable_outs_16x got=%b exp=%b", outs, 4'b0000);
    end
  endtask

  task automatic test_8x();
    logic [2:0] got, exp;
    logic [3:0] outs;
    enable = 1'b0; u2x = 1'b1;
    step();
    enable = 1'b1;
    for (int n = 1; n <= 130; n++) begin
      rx_resync = (n == 42);
      step();
      got = {os_tick, rx_sample, tx_tick};
      exp = {(n % 4 == 0),
             (n == 16) || (n >= 56 && (n - 56) % 32 == 0),
             (n % 32 == 0)};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL run8x edge=%0d os/rx/tx got=%b exp=%b", n, got, exp);
      end
    end
    rx_resync = 1'b0; enable = 1'b0; u2x = 1'b0;
    step();
    outs = {os_tick, rx_sample, tx_tick, inc_pending};
    checks++;
    if (outs !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL disable_outs_8x got=%b exp=%b", outs, 4'b0000);
    end
  endtask

  task automatic test_resync();
    logic [2:0] got, exp;
    enable = 1'b0; u2x = 1'b0;
    step();
    enable = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      rx_resync = (n == 10) || (n == 120);
      step();
      got = {os_tick, rx_sample, tx_tick};
      exp = {(n % 4 == 0), (n == 40) || (n == 104) || (n == 152), (n % 64 == 0)};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL resync edge=%0d os/rx/tx got=%b exp=%b", n, got, exp);
      end
    end
    rx_resync = 1'b0; enable = 1'b0;
    step();
  endtask

  task automatic test_update();
    logic [2:0] got, exp;
    logic [3:0] outs;
    logic       os_exp;
    enable = 1'b1;
    for (int n = 1; n <= 220; n++) begin
      inc_wr   = (n == 20) || (n == 64);
      inc_data = (n == 64) ? 16'd4096 : 16'd8192;
      step();
      if (n <= 64)       os_exp = (n % 4 == 0);
      else if (n <= 192) os_exp = ((n - 64) % 8 == 0);
      else               os_exp = ((n - 192) % 16 == 0);
      got = {os_tick, tx_tick, inc_pending};
      exp = {os_exp, (n == 64) || (n == 192), (n >= 20) && (n < 192)};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL update edge=%0d os/tx/pend got=%b exp=%b", n, got, exp);
      end
    end
    inc_wr = 1'b1; inc_data = 16'd16384;
    step();
    checks++;
    if (inc_pending !== 1'b1) begin
      failures++;
      $display("[TB] FAIL pending_before_disable got=%b exp=1", inc_pending);
    end
    inc_wr = 1'b0; enable = 1'b0;
    step();
    outs = {os_tick, rx_sample, tx_tick, inc_pending};
    checks++;
    if (outs !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL apply_on_disable_outs got=%b exp=%b", outs, 4'b0000);
    end
    enable = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      step();
      checks++;
      if (os_tick !== (n % 4 == 0)) begin
        failures++;
        $display("[TB] FAIL applied_rate edge=%0d os got=%b exp=%b", n, os_tick, (n % 4 == 0));
      end
    end
    enable = 1'b0;
    step();
  endtask

  task automatic test_zero_wrap();
    logic [1:0] got;
    enable = 1'b0; inc_wr = 1'b1; inc_data = 16'd0;
    step();
    inc_wr = 1'b0; enable = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      step();
      got = {os_tick, tx_tick};
      checks++;
      if (got !== 2'b00) begin
        failures++;
        $display("[TB] FAIL zero_inc edge=%0d os/tx got=%b exp=00", n, got);
      end
    end
    enable = 1'b0; inc_wr = 1'b1; inc_data = 16'hFFFF;
    step();
    inc_wr = 1'b0; enable = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      step();
      checks++;
      if (os_tick !== (n >= 2)) begin
        failures++;
        $display("[TB] FAIL max_inc_wrap edge=%0d os got=%b exp=%b", n, os_tick, (n >= 2));
      end
    end
    enable = 1'b0;
    step();
  endtask

  task automatic test_reset_midrun();
    logic [3:0] outs;
    int         tick_count;
    int         first_tick;
    enable = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      inc_wr   = (n == 5);
      inc_data = 16'd8192;
      step();
    end
    inc_wr = 1'b0;
    checks++;
    if (inc_pending !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midrun_pending got=%b exp=1", inc_pending);
    end
    rst = 1'b1; inc_wr = 1'b1; inc_data = 16'd16384; rx_resync = 1'b1;
    step();
    outs = {os_tick, rx_sample, tx_tick, inc_pending};
    checks++;
    if (outs !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_midrun_outs got=%b exp=%b", outs, 4'b0000);
    end
    rst = 1'b0; inc_wr = 1'b0; rx_resync = 1'b0;
    tick_count = 0;
    first_tick = 0;
    for (int n = 1; n <= 65536; n++) begin
      step();
      if (n == 1) begin
        checks++;
        if (inc_pending !== 1'b0) begin
          failures++;
          $display("[TB] FAIL pending_aborted got=%b exp=0", inc_pending);
        end
      end
      if (os_tick === 1'b1) begin
        tick_count++;
        if (first_tick == 0) first_tick = n;
      end
    end
    checks++;
    if (first_tick != 105) begin
      failures++;
      $display("[TB] FAIL rst_inc_first_tick got=%0d exp=105", first_tick);
    end
    checks++;
    if (tick_count < 628 || tick_count > 630) begin
      failures++;
      $display("[TB] FAIL rst_inc_rate got=%0d exp=629+-1", tick_count);
    end
    enable = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_16x();
    test_8x();
    test_resync();
    test_update();
    test_zero_wrap();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_baud_gen.md
UART_BAUD_GEN -- requirements
Module: uart_baud_gen

Interface
REQ-001 The block SHALL have parameter ACC_W, default 16, meaning phase-accumulator fraction width in bits (legal 8..30).
REQ-002 The block SHALL have parameter RST_INC, default 629, meaning the increment loaded at reset (16x of 9600 baud at 16 MHz, ACC_W=16).
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all logic on the rising edge.
REQ-004 The block SHALL have port rst, input, 1, meaning reset; synchronous, active-high.
REQ-005 The block SHALL have port enable, input, 1, meaning run; low means idle or cleared.
REQ-006 The block SHALL have port inc_wr, input, 1, meaning single-cycle strobe that writes inc_data.
REQ-007 The block SHALL have port inc_data, input, ACC_W, meaning the new increment, round(OVS*baud*2^ACC_W/f_clk).
REQ-008 The block SHALL have port u2x, input, 1, meaning the requested double-speed mode (OVS=8 when 1, else 16).
REQ-009 The block SHALL have port rx_resync, input, 1, meaning start-edge pulse that realigns the rx sample phase.
REQ-010 The block SHALL have port os_tick, output, 1, meaning the oversample tick, one cycle wide.
REQ-011 The block SHALL have port rx_sample, output, 1, meaning the mid-bit sample strobe, one cycle wide.
REQ-012 The block SHALL have port tx_tick, output, 1, meaning the bit-period tick, one cycle wide.
REQ-013 The block SHALL have port inc_pending, output, 1, meaning a written increment or u2x value is waiting to be applied.

Function
REQ-014 The accumulator SHALL be ACC_W+1 bits; each enabled edge it SHALL load acc[ACC_W-1:0] + active_inc, with bit ACC_W as the carry.
REQ-015 os_tick SHALL be registered and SHALL equal the carry produced at that edge; with inc=2^(ACC_W-2) it SHALL be high 1 of every 4 cycles, first on the 4th enabled edge.
REQ-016 tx_cnt SHALL count os_ticks from 0 to OVS-1 and wrap; tx_tick SHALL be asserted on the edge whose os_tick wraps tx_cnt.
REQ-017 rx_cnt SHALL count os_ticks 0..OVS-1 with wrap; rx_sample SHALL be asserted on the edge whose os_tick moves rx_cnt from OVS/2-1 to OVS/2.
REQ-018 rx_resync SHALL clear rx_cnt to 0 and SHALL NOT affect acc or tx_cnt; when it coincides with an os_tick, resync wins, that tick is not counted and rx_sample is suppressed.
REQ-019 While enable=0, acc, tx_cnt and rx_cnt SHALL be held at 0 and all tick outputs SHALL be 0.
REQ-020 While enable=0, inc_wr SHALL load active_inc directly and u2x SHALL be copied to the active mode every cycle; inc_pending SHALL stay 0.
REQ-021 While enable=1, inc_wr SHALL store inc_data in a pending register and set inc_pending; a later inc_wr before application SHALL overwrite it.
REQ-022 A pending increment and the current u2x SHALL be applied only on a tx_tick edge; inc_pending SHALL clear on that edge, and rx_cnt SHALL be cleared if the mode changes.
REQ-023 If inc_wr coincides with an applying tx_tick, the new data SHALL become pending, not active, and inc_pending SHALL remain 1.
REQ-024 When enable falls, any pending value SHALL be applied on that edge.
REQ-025 active_inc=0 SHALL produce no ticks; the accumulator SHALL wrap modulo 2^ACC_W without saturation.

Reset
REQ-026 On rst=1 at a clock edge: acc=0, tx_cnt=0, rx_cnt=0, active_inc=RST_INC, pending=0, active mode=16x, and os_tick, rx_sample, tx_tick, inc_pending=0.
REQ-027 rst SHALL override enable, inc_wr and rx_resync in the same cycle; reset mid-frame SHALL abort any pending update.

Structure
REQ-028 The shared package uart_pkg SHALL hold the OVS constants (16, 8), the sample-point constants and the log2/increment-calculation helper function.
REQ-029 The accumulator and carry logic SHALL be one sub-module, baud_phase_acc; the counters, mode and pending logic SHALL stay in uart_baud_gen.

Verification
REQ-030 ACC_W=16, load inc 16384 while idle, enable=1 -> os_tick every 4 cycles, tx_tick at enabled edge 64 and every 64 cycles after that.
REQ-031 Same setup, u2x=1 before enable -> tx_tick every 32 cycles, rx_sample on the 4th os_tick after each resync.
REQ-032 Running 16x, pulse rx_resync on cycle 10, including a case where it coincides with an os_tick -> rx_sample 8 os_ticks later with the coinciding tick not counted, and tx_tick timing unchanged.
REQ-033 Running with inc 16384, write 8192 mid-bit -> inc_pending=1 until the next tx_tick, after which os_tick occurs every 8 cycles; a second write on the tx_tick edge stays pending.
REQ-034 rst=1 asserted mid-run with a pending update -> all outputs 0 on the next edge, and after enable the RST_INC rate (629) is checked against the expected tick count over 2^16 cycles, ±1.
